dds_sweep_ctrl: RTL
===================

// Module: dds_sweep_ctrl
// PURPOSE
//  Sequencer for the dds core: steps the tuning word m from a start to a stop value in fixed
//  increments, holding each tone for a programmable dwell, single-pass or looping.
//  Sits between the communication block (config registers, go/abort pulses) and the dds
//  (en, m, set). Replaces direct host writes of m when a sweep is requested.
// PARAMETERS
//  M_WIDTH      40  tuning-word width; must match the dds m port
//  DWELL_WIDTH  24  dwell counter width, in clk cycles (24 bits ~1.4 s at 12 MHz)
// PORTS
//  clk        in   1            system clock (12 MHz)
//  rst        in   1            synchronous, active-high reset
//  cfg_start  in   M_WIDTH      first tuning word
//  cfg_stop   in   M_WIDTH      last permitted tuning word (inclusive)
//  cfg_step   in   M_WIDTH      increment per tone
//  cfg_dwell  in   DWELL_WIDTH  cycles per tone (0 treated as 1)
//  cfg_repeat in   1            1 = restart at cfg_start after the pass; 0 = single pass
//  go         in   1            1-cycle pulse: start a sweep
//  abort      in   1            1-cycle pulse: stop immediately
//  en         out  1            dds enable
//  m          out  M_WIDTH      tuning word to dds
//  set        out  1            1-cycle load strobe to dds, coincident with a new m
//  busy       out  1            sweep in progress
//  done       out  1            1-cycle pulse: single pass completed normally
//  err        out  1            1-cycle pulse: go rejected (cfg_start > cfg_stop)
// BEHAVIOUR
//  Reset: state IDLE; en=0, m=0, set=0, busy=0, done=0, err=0. All outputs registered.
//  States: IDLE -> TONE -> (TONE | IDLE).
//  - IDLE: on go with cfg_start<=cfg_stop, latch all cfg_* into internal shadow regs;
//    the next cycle m=start, set=1, en=1, busy=1, and the state is TONE. The cfg_* inputs
//    are then ignored until the next IDLE. If cfg_start>cfg_stop, err=1 for one cycle and
//    the block stays in IDLE.
//  - TONE: D=max(dwell,1). Successive set pulses are exactly D cycles apart. set=0 between
//    pulses; m stays stable.
//  - Next word: sum = m + step computed at M_WIDTH+1 bits. End of pass = carry out OR
//    sum>stop. If not end of pass, m=sum and set=1.
//  - End of pass with repeat=1: m=start and set=1; the sweep continues.
//  - End of pass with repeat=0: D cycles after the last set, en=0, busy=0, done=1 for
//    one cycle, and the state is IDLE. m holds the last tone.
//  - step=0: the first tone holds indefinitely (no further set pulses) until abort or rst.
//  - abort, any state: the next cycle en=0, busy=0, set=0, IDLE, done=0. m holds.
//  - Simultaneous events: abort beats go. abort beats end-of-pass (no done). go while
//    busy is ignored.
//  - rst mid-sweep: on the next edge all outputs take their reset values.
// STRUCTURE
//  - Shared header dds_defs.vh: M_WIDTH default, state encodings (ST_IDLE, ST_TONE).
//    dds and communication include the same M_WIDTH.
//  - Sub-module dwell_timer: loadable DWELL_WIDTH down-counter. Inputs load/value.
//    Output expire pulses when the count reaches the terminal value. value 0 loads as 1.
//  - Top-level FSM, shadow regs and the M_WIDTH+1 adder stay in dds_sweep_ctrl.
// TESTING
//  1 start=100 stop=130 step=10 dwell=3 repeat=0, go@T ->
//    set@T+1,T+4,T+7,T+10 with m=100,110,120,130;
//    done@T+13, en=0 and busy=0 from T+13.
//  2 same cfg with repeat=1 -> m=100 with set@T+13, pattern repeats;
//    abort@T+20 -> en=0 and busy=0 @T+21, no done, m holds.
//  3 start=2^40-5 step=10 stop=2^40-1 dwell=2 -> one set (m=2^40-5);
//    carry ends the pass; done 2 cycles later.
//  4 start=50 stop=40, go -> err one cycle, busy/en stay 0, no set;
//    go+abort in the same cycle from IDLE -> nothing starts.
//  5 dwell=0 step=1 start=0 stop=3 -> set on 4 consecutive cycles, m=0..3;
//    step=0 -> single set then hold; a second go while busy is ignored.
//  6 rst asserted mid-sweep (case 2) -> next edge: en=m=set=busy=0;
//    go after rst release restarts cleanly.

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared definitions for the dds sweep sequencer: default widths and FSM state encoding.
package dds_sweep_ctrl_pkg;

  localparam int M_WIDTH_DEF     = 40;
  localparam int DWELL_WIDTH_DEF = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TONE = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Loadable dwell down-counter; expire is high in the last cycle of a D-cycle interval.
module dwell_timer #(
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] value,
  output logic                   expire
);

  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

  // Count saturates at 0 so an unreloaded timer expires exactly once.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == '0) ? DWELL_WIDTH'(1) : value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == DWELL_WIDTH'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer for the dds core: steps m from start to stop with a fixed dwell per tone.
// Handshake: go/abort are single-cycle request pulses with no ready; set is a one-cycle strobe.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int M_WIDTH     = M_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M_WIDTH-1:0]     cfg_start,
  input  logic [M_WIDTH-1:0]     cfg_stop,
  input  logic [M_WIDTH-1:0]     cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_repeat,
  input  logic                   go,
  input  logic                   abort,
  output logic                   en,
  output logic [M_WIDTH-1:0]     m,
  output logic                   set,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output sweep_state_e           dbg_state
);

  sweep_state_e           state_q, state_d;
  logic [M_WIDTH-1:0]     m_q, m_d;
  logic                   en_q, en_d, set_q, set_d, busy_q, busy_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [M_WIDTH-1:0]     start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   repeat_q, repeat_d;

  logic                   tmr_load, tmr_expire;
  logic [DWELL_WIDTH-1:0] tmr_value;
  logic [M_WIDTH:0]       sum;
  logic                   end_of_pass;

  // Extra bit catches wrap past 2^M_WIDTH, which must end the pass.
  assign sum         = {1'b0, m_q} + {1'b0, step_q};
  assign end_of_pass = sum[M_WIDTH] | (sum[M_WIDTH-1:0] > stop_q);

  dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    en_d      = en_q;
    busy_d    = busy_q;
    set_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    repeat_d  = repeat_q;
    tmr_load  = 1'b0;
    tmr_value = dwell_q;
    if (abort) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            if (cfg_start <= cfg_stop) begin
              start_d   = cfg_start;
              stop_d    = cfg_stop;
              step_d    = cfg_step;
              dwell_d   = cfg_dwell;
              repeat_d  = cfg_repeat;
              m_d       = cfg_start;
              set_d     = 1'b1;
              en_d      = 1'b1;
              busy_d    = 1'b1;
              tmr_load  = 1'b1;
              tmr_value = cfg_dwell;
              state_d   = ST_TONE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_TONE: begin
          // A zero step parks on the first tone: the timer is left to run out.
          if (tmr_expire && (step_q != '0)) begin
            if (!end_of_pass) begin
              m_d      = sum[M_WIDTH-1:0];
              set_d    = 1'b1;
              tmr_load = 1'b1;
            end else if (repeat_q) begin
              m_d      = start_q;
              set_d    = 1'b1;
              tmr_load = 1'b1;
            end else begin
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      en_q     <= 1'b0;
      set_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      en_q     <= en_d;
      set_q    <= set_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      repeat_q <= repeat_d;
    end
  end

  assign en        = en_q;
  assign m         = m_q;
  assign set       = set_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
